param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 109 ++++++++++
 tb/tb_param_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy flags, overflow/underflow pulses,
// a high-water mark, and either registered-read or first-word-fall-through output.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AE_THRESH  = 2,
  parameter int AF_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       clr_peak,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid,
  output logic                       empty,
  output logic                       almost_empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  rd_acc;
  logic                  wr_acc;

  // A read frees a slot in the same cycle, so a full FIFO can still accept a
  // simultaneous write; an empty FIFO never forwards the incoming word to a read.
  assign rd_acc = rd_en && (count != '0);
  assign wr_acc = wr_en && ((count != FULL_CNT) || rd_acc);

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)
      count_next = count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      peak      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
      if (clr_peak)
        peak <= count_next;
      else if (count_next > peak)
        peak <= count_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale words are never
  // observable because count and the pointers are.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wr_ptr] <= data_in;
  end

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_empty = (count != '0) && (count <= AE_CNT);
  assign almost_full  = (count >= AF_CNT) && (count != FULL_CNT);

  generate
    if (FWFT) begin : g_fwft
      // Masked while empty so nothing left over from before a reset leaks out.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign valid    = !empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out <= '0;
          valid    <= 1'b0;
        end else begin
          valid <= rd_acc;
          if (rd_acc)
            data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench: a standard-read instance and a FWFT instance,
// both at default sizes, driven with hand-computed expected values.
module tb_param_fifo;

  localparam int DW = 8;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Standard-read instance
  logic          wr_en, rd_en, clr_peak;
  logic [DW-1:0] data_in, data_out;
  logic          valid, empty, almost_empty, full, almost_full, overflow, underflow;
  logic [CW-1:0] count, peak;

  // FWFT instance
  logic          f_wr_en, f_rd_en, f_clr_peak;
  logic [DW-1:0] f_data_in, f_data_out;
  logic          f_valid, f_empty, f_almost_empty, f_full, f_almost_full, f_overflow, f_underflow;
  logic [CW-1:0] f_count, f_peak;

  param_fifo #(.FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .clr_peak(clr_peak), .data_out(data_out), .valid(valid), .empty(empty),
    .almost_empty(almost_empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .count(count), .peak(peak)
  );

  param_fifo #(.FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .rd_en(f_rd_en), .data_in(f_data_in),
    .clr_peak(f_clr_peak), .data_out(f_data_out), .valid(f_valid), .empty(f_empty),
    .almost_empty(f_almost_empty), .full(f_full), .almost_full(f_almost_full),
    .overflow(f_overflow), .underflow(f_underflow), .count(f_count), .peak(f_peak)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; clr_peak = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_peak = 0;
  endtask

  initial begin
    int max_cnt;
    idle();
    data_in = '0; f_data_in = '0;
    rst_n = 0;
    cycle(); cycle();

    // Reset state
    check("rst_count", count, 0);
    check("rst_peak", peak, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 0);
    check("rst_af", almost_full, 0);
    check("rst_valid", valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1;

    // Fill 0..31
    for (int i = 0; i < 32; i++) begin
      wr_en = 1; data_in = DW'(i);
      cycle();
      check($sformatf("fill_count_%0d", i), count, i + 1);
      if (i == 28) check("af_at_29", almost_full, 0);
      if (i == 29) check("af_at_30", almost_full, 1);
      if (i == 30) check("full_at_31", full, 0);
      if (i == 31) begin
        check("full_at_32", full, 1);
        check("af_at_32", almost_full, 0);
      end
    end
    data_in = 8'h99;
    cycle();
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 32);
    check("ovf_peak", peak, 32);
    idle();
    cycle();
    check("ovf_clear", overflow, 0);

    // Drain, 1-cycle read latency
    for (int i = 0; i < 32; i++) begin
      rd_en = 1;
      cycle();
      check($sformatf("drain_data_%0d", i), data_out, i);
      check($sformatf("drain_valid_%0d", i), valid, 1);
      if (i == 28) check("ae_at_3", almost_empty, 0);
      if (i == 29) check("ae_at_2", almost_empty, 1);
    end
    check("drain_count", count, 0);
    cycle();
    check("unf_pulse", underflow, 1);
    check("unf_hold", data_out, 31);
    check("unf_valid", valid, 0);
    check("unf_empty", empty, 1);
    check("unf_ae", almost_empty, 0);
    idle();
    cycle();
    check("unf_clear", underflow, 0);
    check("hold_idle", data_out, 31);

    // Simultaneous write+read at empty
    wr_en = 1; rd_en = 1; data_in = 8'h5A;
    cycle();
    check("we_empty_count", count, 1);
    check("we_empty_unf", underflow, 1);
    check("we_empty_ae", almost_empty, 1);
    check("we_empty_valid", valid, 0);
    idle(); rd_en = 1;
    cycle();
    check("we_empty_data", data_out, 8'h5A);
    check("we_empty_drained", count, 0);
    idle();

    // Wrap: interleaved pairs across the pointer boundary
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1; data_in = DW'(i); rd_en = (i > 0);
      cycle();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (i > 0) check($sformatf("wrap_data_%0d", i - 1), data_out, i - 1);
    end
    idle(); rd_en = 1;
    cycle();
    check("wrap_last", data_out, 8'h27);
    check("wrap_maxcnt_le2", (max_cnt <= 2) ? 32'd1 : 32'd0, 1);
    idle();

    // Simultaneous write+read at full
    for (int i = 0; i < 32; i++) begin
      wr_en = 1; data_in = DW'(8'h80 + i);
      cycle();
    end
    check("refill_full", full, 1);
    wr_en = 1; rd_en = 1; data_in = 8'hEE;
    cycle();
    check("wr_full_count", count, 32);
    check("wr_full_data", data_out, 8'h80);
    idle();
    cycle();
    check("wr_full_no_ovf", overflow, 0);

    // Reset mid-fill at count 10
    rst_n = 0; cycle(); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; data_in = DW'(i);
      cycle();
    end
    check("mid_count10", count, 10);
    rst_n = 0; wr_en = 1; rd_en = 1; clr_peak = 1;
    cycle();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_peak", peak, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_af", almost_full, 0);
    check("mid_rst_ae", almost_empty, 0);
    check("mid_rst_unf", underflow, 0);
    check("mid_rst_valid", valid, 0);
    rst_n = 1; idle();

    // clr_peak at count 5 after peak 12
    for (int i = 0; i < 12; i++) begin
      wr_en = 1; data_in = DW'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 7; i++) begin
      rd_en = 1;
      cycle();
    end
    idle();
    check("peak_12", peak, 12);
    check("count_5", count, 5);
    clr_peak = 1;
    cycle();
    check("clr_peak_5", peak, 5);
    idle();
    cycle();
    check("peak_stays_5", peak, 5);

    // FWFT instance
    check("f_empty_start", f_valid, 0);
    f_wr_en = 1; f_data_in = 8'hA5;
    cycle();
    f_wr_en = 0;
    check("f_data_a5", f_data_out, 8'hA5);
    check("f_valid_a5", f_valid, 1);
    cycle();
    check("f_hold_a5", f_data_out, 8'hA5);
    f_rd_en = 1;
    cycle();
    f_rd_en = 0;
    check("f_pop_empty", f_empty, 1);
    check("f_pop_valid", f_valid, 0);
    f_wr_en = 1; f_data_in = 8'hB1;
    cycle();
    f_data_in = 8'hB2;
    cycle();
    f_wr_en = 0;
    check("f_head_b1", f_data_out, 8'hB1);
    f_rd_en = 1;
    cycle();
    f_rd_en = 0;
    check("f_next_b2", f_data_out, 8'hB2);
    check("f_count_1", f_count, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    check("f_rst_valid", f_valid, 0);
    check("f_rst_dout", f_data_out, 0);
    check("f_rst_count", f_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
